// File: rtl/vga_frame_fetch_pkg.sv
// Shared constants and FSM encoding for the VGA scan-out fetch stage.
package vga_frame_fetch_pkg;

  localparam int unsigned DEF_ADDR_SIZE  = 8;
  localparam int unsigned DEF_REG_SIZE   = 8;
  localparam int unsigned DEF_FB_W       = 16;
  localparam int unsigned DEF_FB_H       = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/vga_frame_fetch_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; head is read straight from registered storage.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gated to zero when empty so the head never shows stale storage.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/vga_frame_fetch.sv
// Frame fetch: reads FB_W*FB_H pixels from shared memory per frame_start and streams them with eol/eof tags.
module vga_frame_fetch
  import vga_frame_fetch_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int unsigned REG_SIZE   = DEF_REG_SIZE,
  parameter int unsigned FB_W       = DEF_FB_W,
  parameter int unsigned FB_H       = DEF_FB_H,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [ADDR_SIZE-1:0] fb_base,
  output logic                 rd_req,
  output logic [ADDR_SIZE-1:0] rd_addr,
  input  logic                 rd_gnt,
  input  logic                 rd_valid,
  input  logic [REG_SIZE-1:0]  rd_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [REG_SIZE-1:0]  pix_data,
  output logic                 pix_eol,
  output logic                 pix_eof,
  output logic                 busy,
  output logic [7:0]           underrun_cnt
);

  localparam int unsigned NPIX  = FB_W * FB_H;
  localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned COL_W = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DSC_W = $clog2(2 * FIFO_DEPTH + 1);

  fetch_state_e         state;
  fetch_state_e         state_nxt;
  logic [ADDR_SIZE-1:0] base;
  logic [IDX_W-1:0]     idx;
  logic [COL_W-1:0]     col;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     fifo_count;
  logic [DSC_W-1:0]     discard;
  logic [DSC_W-1:0]     stale_in;
  logic                 tag_eol;
  logic                 tag_eof;
  logic                 credit_ok;
  logic                 accept_gnt;
  logic                 last_gnt;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [REG_SIZE+1:0]  head;

  assign credit_ok  = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(FIFO_DEPTH);
  assign accept_gnt = rd_req && rd_gnt;
  assign last_gnt   = accept_gnt && (idx == IDX_W'(NPIX - 1));
  assign rd_addr    = base + ADDR_SIZE'(idx);
  assign stale_in   = discard + DSC_W'(outstanding);
  // Returns still owed to an aborted frame are consumed by discard before any push.
  assign push       = rd_valid && !frame_start && (discard == '0) && (outstanding != '0);
  assign pop        = !fifo_empty && pix_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = ST_FETCH;
    end else begin
      unique case (state)
        ST_FETCH: if (last_gnt) state_nxt = ST_DRAIN;
        ST_DRAIN: if (fifo_empty && (outstanding == '0)) state_nxt = ST_IDLE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    rd_req = (state == ST_FETCH) && credit_ok && !frame_start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base         <= '0;
      idx          <= '0;
      col          <= '0;
      outstanding  <= '0;
      discard      <= '0;
      tag_eol      <= 1'b0;
      tag_eof      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (busy && pix_ready && fifo_empty && (underrun_cnt != 8'hFF))
        underrun_cnt <= underrun_cnt + 8'd1;

      if (frame_start) begin
        base        <= fb_base;
        idx         <= '0;
        col         <= '0;
        outstanding <= '0;
        discard     <= (rd_valid && (stale_in != '0)) ? stale_in - DSC_W'(1) : stale_in;
      end else begin
        if (accept_gnt) begin
          idx     <= idx + IDX_W'(1);
          col     <= (col == COL_W'(FB_W - 1)) ? '0 : col + COL_W'(1);
          // Data returns exactly one cycle after grant, so a single tag stage suffices.
          tag_eol <= (col == COL_W'(FB_W - 1));
          tag_eof <= (idx == IDX_W'(NPIX - 1));
        end
        if (rd_valid && (discard != '0)) discard <= discard - DSC_W'(1);
        unique case ({accept_gnt, push})
          2'b10:   outstanding <= outstanding + CNT_W'(1);
          2'b01:   outstanding <= outstanding - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(REG_SIZE + 2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (frame_start),
    .push    (push),
    .wr_data ({tag_eof, tag_eol, rd_data}),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pix_valid = !fifo_empty;
  assign {pix_eof, pix_eol, pix_data} = head;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Randomized bench for vga_frame_fetch against a queue-based frame/credit reference model.
module tb_vga_frame_fetch;

  localparam int unsigned N = 256;
  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [7:0] fb_base;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic       pix_eol;
  logic       pix_eof;
  logic       busy;
  logic [7:0] underrun_cnt;

  always #5 clk = ~clk;

  vga_frame_fetch #(
    .ADDR_SIZE(8),
    .REG_SIZE(8),
    .FB_W(W),
    .FB_H(16),
    .FIFO_DEPTH(D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .fb_base      (fb_base),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_eol      (pix_eol),
    .pix_eof      (pix_eof),
    .busy         (busy),
    .underrun_cnt (underrun_cnt)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame progress, in-order pixel queue, credits, underruns.
  logic [7:0]  mem [256];
  bit          m_busy, m_fetch;
  int unsigned m_idx, m_out, m_under;
  logic [7:0]  m_base;
  logic [9:0]  m_q[$];
  bit          ret_pend;
  logic [7:0]  ret_addr;
  logic [9:0]  ret_entry;
  int unsigned dut_pops, dut_eols, dut_eofs, grants;
  logic [7:0]  first_pix;

  task automatic model_reset();
    m_busy = 0; m_fetch = 0; m_idx = 0; m_out = 0; m_under = 0; m_base = '0;
    m_q.delete(); ret_pend = 0; ret_addr = '0; ret_entry = '0;
    dut_pops = 0; dut_eols = 0; dut_eofs = 0; grants = 0; first_pix = '0;
  endtask

  task automatic cycle(input bit fs, input logic [7:0] base, input int unsigned gp, input int unsigned rp);
    bit         exp_req, g, pop, push, go_idle;
    logic [9:0] entry;
    @(negedge clk);
    frame_start = fs;
    fb_base     = base;
    pix_ready   = ($urandom_range(99) < rp);
    rd_valid    = ret_pend;
    rd_data     = ret_pend ? mem[ret_addr] : 8'($urandom);
    #1;
    exp_req = m_busy && m_fetch && !fs && ((m_q.size() + m_out) < D);
    check("rd_req", rd_req, exp_req);
    check("busy", busy, m_busy);
    check("pix_valid", pix_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("pix_head", {pix_eof, pix_eol, pix_data}, m_q[0]);
    check("underrun_cnt", underrun_cnt, m_under);
    if (exp_req) check("rd_addr", rd_addr, 8'(m_base + m_idx));
    rd_gnt = rd_req && ($urandom_range(99) < gp);
    g = (rd_gnt === 1'b1);

    if (fs) begin
      dut_pops = 0; dut_eols = 0; dut_eofs = 0; grants = 0;
    end else if (pix_valid && pix_ready) begin
      if (dut_pops == 0) first_pix = pix_data;
      dut_pops++;
      dut_eols += pix_eol;
      dut_eofs += pix_eof;
    end
    if (g) grants++;

    if (m_busy && pix_ready && (m_q.size() == 0) && (m_under < 255)) m_under++;
    entry   = {1'(m_idx == N - 1), 1'((m_idx % W) == W - 1), mem[8'(m_base + m_idx)]};
    pop     = (m_q.size() != 0) && pix_ready;
    push    = ret_pend && !fs;
    go_idle = m_busy && !m_fetch && (m_q.size() == 0) && (m_out == 0);
    if (fs) begin
      m_q.delete();
      m_busy = 1; m_fetch = 1; m_idx = 0; m_out = 0; m_base = base;
    end else begin
      if (go_idle) m_busy = 0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(ret_entry);
        m_out--;
      end
      if (g) begin
        m_out++;
        m_idx++;
        if (m_idx == N) m_fetch = 0;
      end
    end
    ret_pend  = g;
    ret_entry = entry;
    ret_addr  = rd_addr;
    @(posedge clk);
  endtask

  task automatic finish_frame(input logic [7:0] base, input int unsigned gp, input int unsigned rp);
    int unsigned n = 0;
    while (m_busy && n < 5000) begin
      cycle(1'b0, base, gp, rp);
      n++;
    end
    #1;
    check("frame_done_busy", busy, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] base, input int unsigned gp, input int unsigned rp);
    cycle(1'b1, base, gp, rp);
    finish_frame(base, gp, rp);
    check("frame_pixels", dut_pops, N);
    check("frame_eols", dut_eols, N / W);
    check("frame_eofs", dut_eofs, 1);
    check("frame_first_pix", first_pix, mem[base]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_req"}, rd_req, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_eol"}, pix_eol, 0);
    check({tag, "_pix_eof"}, pix_eof, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underrun"}, underrun_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; frame_start = 1'b0; fb_base = '0; rd_gnt = 1'b0;
    rd_valid = 1'b0; rd_data = '0; pix_ready = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b1;
    repeat (5) cycle(1'b0, 8'h00, 100, 100);

    // Full-rate frame with address wrap past 0xFF.
    run_frame(8'h40, 100, 100);
    check("wrap_grants", grants, N);

    // Consumer stalled: credit limit caps grants at FIFO depth.
    cycle(1'b1, 8'h10, 100, 0);
    repeat (30) cycle(1'b0, 8'h10, 100, 0);
    check("stall_grants", grants, D);
    check("stall_rd_req", rd_req, 0);
    finish_frame(8'h10, 100, 100);
    check("stall_pixels", dut_pops, N);

    // Sparse grants cause underruns; then saturation with no grants at all.
    run_frame(8'hC3, 30, 100);
    cycle(1'b1, 8'h00, 0, 100);
    repeat (300) cycle(1'b0, 8'h00, 0, 100);
    #1;
    check("underrun_sat", underrun_cnt, 8'hFF);
    finish_frame(8'h00, 100, 100);

    // Restart mid-frame after pixel 37.
    begin
      int unsigned n = 0;
      cycle(1'b1, 8'h40, 60, 70);
      while (dut_pops < 37 && n < 3000) begin
        cycle(1'b0, 8'h40, 60, 70);
        n++;
      end
      check("restart_reached_37", dut_pops, 37);
    end
    run_frame(8'hA7, 60, 70);

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 8'h55, 100, 50);
    repeat (20) cycle(1'b0, 8'h55, 100, 50);
    @(negedge clk);
    frame_start = 1'b0; rd_gnt = 1'b0; rd_valid = 1'b0; pix_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (6) cycle(1'b0, 8'h00, 100, 100);
    run_frame(8'hF0, 100, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
